// File: rtl/scr1_dmem_sram_resp_pkg.sv
// DMEM interface types and access helpers shared by the DMEM responder,
// the SRAM wrapper and the DMEM router.
package scr1_dmem_sram_resp_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;
    localparam int SCR1_WAIT_CNT_W  = 4;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // Byte-lane enables touched by an access of the given width at the given
    // byte offset inside the word; an unknown width touches nothing.
    function automatic logic [3:0] scr1_mem_be(
        input type_scr1_mem_width_e width,
        input logic [1:0]           offset
    );
        logic [3:0] be;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << offset;
            SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << offset;
            SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

    // Copies right-aligned store data into every lane it could land on, so
    // the byte enables alone select the bytes that get written.
    function automatic logic [31:0] scr1_mem_wdata_repl(
        input type_scr1_mem_width_e width,
        input logic [31:0]          wdata
    );
        logic [31:0] repl;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  repl = {4{wdata[7:0]}};
            SCR1_MEM_WIDTH_HWORD: repl = {2{wdata[15:0]}};
            default:              repl = wdata;
        endcase
        return repl;
    endfunction

    // True for an illegal width or an access not naturally aligned to its size.
    function automatic logic scr1_mem_misaligned(
        input type_scr1_mem_width_e width,
        input logic [1:0]           offset
    );
        logic bad;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  bad = 1'b0;
            SCR1_MEM_WIDTH_HWORD: bad = offset[0];
            SCR1_MEM_WIDTH_WORD:  bad = (offset != 2'b00);
            default:              bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/scr1_dmem_ld_align.sv
// Load alignment: moves the addressed bytes of an SRAM word down to bit 0 and
// zeroes everything above the access width.
module scr1_dmem_ld_align
    import scr1_dmem_sram_resp_pkg::*;
(
    input  logic [31:0]          sram_rdata,
    input  logic [1:0]           offset,
    input  type_scr1_mem_width_e width,
    output logic [31:0]          ld_data
);

    logic [31:0] shifted;

    // Shift the addressed lane to bit 0, then mask to the access width.
    always_comb begin
        shifted = sram_rdata >> {offset, 3'b000};
        ld_data = '0;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  ld_data = {24'd0, shifted[7:0]};
            SCR1_MEM_WIDTH_HWORD: ld_data = {16'd0, shifted[15:0]};
            SCR1_MEM_WIDTH_WORD:  ld_data = shifted;
            default:              ld_data = '0;
        endcase
    end

endmodule

// File: rtl/scr1_dmem_sram_resp.sv
// DMEM responder in front of a single-port synchronous SRAM (1-cycle read
// latency). Accepts one request at a time, range/alignment checks it, strobes
// the SRAM for legal accesses and answers with RDY_OK or RDY_ER after
// WAIT_CYCLES extra cycles.
module scr1_dmem_sram_resp
    import scr1_dmem_sram_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned SIZE_BYTES  = 4096,
    parameter int unsigned WAIT_CYCLES = 0,
    localparam int unsigned OFF_W      = $clog2(SIZE_BYTES),
    localparam int unsigned SRAM_AW    = OFF_W - 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic                        dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp,
    output logic                        sram_ce,
    output logic                        sram_we,
    output logic [3:0]                  sram_be,
    output logic [SRAM_AW-1:0]          sram_addr,
    output logic [31:0]                 sram_wdata,
    input  logic [31:0]                 sram_rdata
);

    typedef enum logic [1:0] {
        SCR1_DMEM_RESP_FSM_IDLE = 2'b00,
        SCR1_DMEM_RESP_FSM_WAIT = 2'b01,
        SCR1_DMEM_RESP_FSM_RESP = 2'b10
    } type_scr1_dmem_resp_fsm_e;

    // Counter preload: the WAIT state lasts WAIT_CYCLES cycles, leaving on zero.
    localparam logic [SCR1_WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : SCR1_WAIT_CNT_W'(WAIT_CYCLES - 1);

    type_scr1_dmem_resp_fsm_e   state;
    logic [SCR1_WAIT_CNT_W-1:0] wait_cnt;
    logic                       rsp_err;
    logic                       rsp_rd;
    logic [1:0]                 offset;
    type_scr1_mem_width_e       width;
    logic [31:0]                rd_q;
    logic                       rd_vld_p1;

    logic                       in_range;
    logic                       req_err;
    logic [31:0]                ld_data;

    // Request decode: window hit, legality, acceptance and SRAM strobes.
    always_comb begin
        in_range     = (dmem_addr[SCR1_DMEM_AWIDTH-1:OFF_W] == BASE_ADDR[SCR1_DMEM_AWIDTH-1:OFF_W]);
        req_err      = ~in_range | scr1_mem_misaligned(dmem_width, dmem_addr[1:0]);
        dmem_req_ack = dmem_req & (state == SCR1_DMEM_RESP_FSM_IDLE) & ~rst;
        sram_ce      = dmem_req_ack & ~req_err;
        sram_we      = sram_ce & (dmem_cmd == SCR1_MEM_CMD_WR);
        sram_be      = sram_we ? scr1_mem_be(dmem_width, dmem_addr[1:0]) : 4'b0000;
        sram_addr    = dmem_addr[OFF_W-1:2];
        sram_wdata   = scr1_mem_wdata_repl(dmem_width, dmem_wdata);
    end

    scr1_dmem_ld_align u_ld_align (
        .sram_rdata (sram_rdata),
        .offset     (offset),
        .width      (width),
        .ld_data    (ld_data)
    );

    // Transaction FSM with registered response code and read-data holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCR1_DMEM_RESP_FSM_IDLE;
            wait_cnt  <= '0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
            offset    <= '0;
            width     <= SCR1_MEM_WIDTH_BYTE;
            rd_q      <= '0;
            rd_vld_p1 <= 1'b0;
            dmem_resp <= SCR1_MEM_RESP_NOTRDY;
        end else begin
            // --- stage p1: SRAM word of the previous-cycle read is on sram_rdata ---
            rd_vld_p1 <= sram_ce & ~sram_we;
            if (rd_vld_p1) begin
                rd_q <= ld_data;
            end
            case (state)
                SCR1_DMEM_RESP_FSM_IDLE: begin
                    if (dmem_req_ack) begin
                        rsp_err  <= req_err;
                        rsp_rd   <= ~req_err & (dmem_cmd == SCR1_MEM_CMD_RD);
                        offset   <= dmem_addr[1:0];
                        width    <= dmem_width;
                        wait_cnt <= WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            state     <= SCR1_DMEM_RESP_FSM_RESP;
                            dmem_resp <= req_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                        end else begin
                            state <= SCR1_DMEM_RESP_FSM_WAIT;
                        end
                    end
                end
                SCR1_DMEM_RESP_FSM_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= SCR1_DMEM_RESP_FSM_RESP;
                        dmem_resp <= rsp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                SCR1_DMEM_RESP_FSM_RESP: begin
                    state     <= SCR1_DMEM_RESP_FSM_IDLE;
                    dmem_resp <= SCR1_MEM_RESP_NOTRDY;
                end
                default: begin
                    state     <= SCR1_DMEM_RESP_FSM_IDLE;
                    dmem_resp <= SCR1_MEM_RESP_NOTRDY;
                end
            endcase
        end
    end

    // Load data: live SRAM word when there are no wait states, held copy otherwise.
    always_comb begin
        dmem_rdata = '0;
        if ((state == SCR1_DMEM_RESP_FSM_RESP) && rsp_rd) begin
            dmem_rdata = (WAIT_CYCLES == 0) ? ld_data : rd_q;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_sram_resp.sv
// Bench for scr1_dmem_sram_resp: one instance without wait states, one with
// two, each behind a behavioural SRAM, checked against a byte-array model.
module tb_scr1_dmem_sram_resp;
    import scr1_dmem_sram_resp_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          SIZE = 4096;

    typedef struct {
        logic        ack, ce, we;
        logic [3:0]  be;
        logic [9:0]  saddr;
        logic [31:0] swdata;
        logic [1:0]  resp_t;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        bit          timeout;
    } obs_t;

    logic                 clk = 1'b0;
    logic                 rst   [2];
    logic                 req   [2];
    type_scr1_mem_cmd_e   cmd   [2];
    type_scr1_mem_width_e wid   [2];
    logic [31:0]          addr  [2];
    logic [31:0]          wdat  [2];
    logic                 ack   [2];
    logic                 ce    [2];
    logic                 we    [2];
    logic [3:0]           be    [2];
    logic [9:0]           saddr [2];
    logic [31:0]          swdat [2];
    logic [31:0]          srd   [2];
    logic [31:0]          rdat  [2];
    type_scr1_mem_resp_e  rsp   [2];

    logic [31:0] sram_mem [2][1024] = '{default: '0};
    logic [7:0]  ref_mem  [2][4096];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scr1_dmem_sram_resp #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .dmem_req(req[0]), .dmem_cmd(cmd[0]), .dmem_width(wid[0]),
        .dmem_addr(addr[0]), .dmem_wdata(wdat[0]), .dmem_req_ack(ack[0]), .dmem_rdata(rdat[0]),
        .dmem_resp(rsp[0]), .sram_ce(ce[0]), .sram_we(we[0]), .sram_be(be[0]),
        .sram_addr(saddr[0]), .sram_wdata(swdat[0]), .sram_rdata(srd[0])
    );

    scr1_dmem_sram_resp #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst[1]), .dmem_req(req[1]), .dmem_cmd(cmd[1]), .dmem_width(wid[1]),
        .dmem_addr(addr[1]), .dmem_wdata(wdat[1]), .dmem_req_ack(ack[1]), .dmem_rdata(rdat[1]),
        .dmem_resp(rsp[1]), .sram_ce(ce[1]), .sram_we(we[1]), .sram_be(be[1]),
        .sram_addr(saddr[1]), .sram_wdata(swdat[1]), .sram_rdata(srd[1])
    );

    // Behavioural single-port SRAMs with byte enables and 1-cycle read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ce[d] === 1'b1) begin
                if (we[d]) begin
                    for (int i = 0; i < 4; i++)
                        if (be[d][i]) sram_mem[d][saddr[d]][8*i +: 8] <= swdat[d][8*i +: 8];
                end else begin
                    srd[d] <= sram_mem[d][saddr[d]];
                end
            end
        end
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int nbytes(input type_scr1_mem_width_e w);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return 1;
            SCR1_MEM_WIDTH_HWORD: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit model_err(input type_scr1_mem_width_e w, input logic [31:0] a);
        if (w == SCR1_MEM_WIDTH_ERROR) return 1'b1;
        if (a < BASE || a >= BASE + SIZE) return 1'b1;
        if ((a % nbytes(w)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int d, input type_scr1_mem_width_e w, input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(w); i++) v[8*i +: 8] = ref_mem[d][int'(a - BASE) + i];
        return v;
    endfunction

    // Drives one request until accepted (bounded), records the accept-cycle
    // outputs, then waits (bounded) for the first non-NOTRDY response.
    task automatic xact(input int d, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] wd, output obs_t o);
        int n = 0;
        o.timeout = 1'b0;
        @(posedge clk); #1;
        req[d] = 1'b1; cmd[d] = c; wid[d] = w; addr[d] = a; wdat[d] = wd;
        @(negedge clk);
        while (ack[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        o.ack = ack[d]; o.ce = ce[d]; o.we = we[d]; o.be = be[d];
        o.saddr = saddr[d]; o.swdata = swdat[d]; o.resp_t = rsp[d];
        if (ack[d] !== 1'b1) o.timeout = 1'b1;
        @(posedge clk); #1;
        req[d] = 1'b0;
        if (o.ack === 1'b1 && !model_err(w, a) && c == SCR1_MEM_CMD_WR)
            for (int i = 0; i < nbytes(w); i++) ref_mem[d][int'(a - BASE) + i] = wd[8*i +: 8];
        o.lat = 1;
        @(negedge clk);
        while (rsp[d] === SCR1_MEM_RESP_NOTRDY && o.lat < 20) begin @(negedge clk); o.lat++; end
        o.resp = rsp[d]; o.rdata = rdat[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b1; cmd[d] = SCR1_MEM_CMD_WR; wid[d] = SCR1_MEM_WIDTH_WORD;
            addr[d] = BASE; wdat[d] = 32'hFFFF_FFFF;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ack[d], ce[d], we[d], be[d]} !== 7'b0) begin
                failures++; $display("FAIL reset_comb d=%0d got=%b exp=0000000", d, {ack[d], ce[d], we[d], be[d]});
            end
            checks++;
            if (rsp[d] !== SCR1_MEM_RESP_NOTRDY || rdat[d] !== 32'h0) begin
                failures++; $display("FAIL reset_resp d=%0d got resp=%0d rdata=%h exp resp=0 rdata=0", d, rsp[d], rdat[d]);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin rst[d] = 1'b0; req[d] = 1'b0; end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp[d] !== SCR1_MEM_RESP_NOTRDY || ack[d] !== 1'b0) begin
                failures++; $display("FAIL post_reset_idle d=%0d got resp=%0d ack=%b exp 0 0", d, rsp[d], ack[d]);
            end
        end
    endtask

    task automatic test_store_load();
        obs_t o;
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0001_0004, 32'hDEAD_BEEF, o);
        checks++;
        if ({o.ack, o.ce, o.we, o.be} !== 7'b111_1111 || o.saddr !== 10'd1) begin
            failures++; $display("FAIL sw_strobe got ack/ce/we/be=%b addr=%0d exp 1111111 addr=1", {o.ack, o.ce, o.we, o.be}, o.saddr);
        end
        checks++;
        if (o.lat != 1 || o.resp !== SCR1_MEM_RESP_RDY_OK || o.rdata !== 32'h0) begin
            failures++; $display("FAIL sw_resp got lat=%0d resp=%0d rdata=%h exp 1 1 0", o.lat, o.resp, o.rdata);
        end
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0001_0004, 32'h0, o);
        checks++;
        if ({o.ce, o.we, o.be} !== 6'b10_0000 || o.lat != 1 || o.resp !== SCR1_MEM_RESP_RDY_OK || o.rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL lw got ce/we/be=%b lat=%0d resp=%0d rdata=%h exp 100000 1 1 deadbeef", {o.ce, o.we, o.be}, o.lat, o.resp, o.rdata);
        end
        xact(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h0001_0006, 32'h0000_00A5, o);
        checks++;
        if (o.be !== 4'b0100 || o.swdata !== 32'hA5A5_A5A5 || o.resp !== SCR1_MEM_RESP_RDY_OK) begin
            failures++; $display("FAIL sb got be=%b wdata=%h resp=%0d exp 0100 a5a5a5a5 1", o.be, o.swdata, o.resp);
        end
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h0001_0006, 32'h0, o);
        checks++;
        if (o.resp !== SCR1_MEM_RESP_RDY_OK || o.rdata !== 32'h0000_00A5) begin
            failures++; $display("FAIL lbu got resp=%0d rdata=%h exp 1 000000a5", o.resp, o.rdata);
        end
        xact(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h0001_0006, 32'h0, o);
        checks++;
        if (o.resp !== SCR1_MEM_RESP_RDY_OK || o.rdata !== 32'h0000_DEA5) begin
            failures++; $display("FAIL lh got resp=%0d rdata=%h exp 1 0000dea5", o.resp, o.rdata);
        end
    endtask

    task automatic test_error();
        logic [31:0]          ta [7] = '{32'h0001_0002, 32'h0002_0000, 32'h0001_0000, 32'h0001_0001,
                                         32'h0001_0FFC, 32'h0001_1000, 32'h0000_FFFC};
        type_scr1_mem_width_e tw [7] = '{SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_ERROR,
                                         SCR1_MEM_WIDTH_HWORD, SCR1_MEM_WIDTH_WORD, SCR1_MEM_WIDTH_WORD,
                                         SCR1_MEM_WIDTH_WORD};
        type_scr1_mem_cmd_e   tc [7] = '{SCR1_MEM_CMD_RD, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR,
                                         SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR, SCR1_MEM_CMD_RD};
        bit                   te [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        obs_t o;
        for (int k = 0; k < 7; k++) begin
            xact(0, tc[k], tw[k], ta[k], 32'h5555_AAAA, o);
            checks++;
            if (o.ack !== 1'b1 || o.ce !== !te[k] || o.lat != 1 ||
                o.resp !== (te[k] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK) || o.rdata !== 32'h0) begin
                failures++;
                $display("FAIL err_case%0d addr=%h got ack=%b ce=%b lat=%0d resp=%0d rdata=%h exp ack=1 ce=%b lat=1 err=%b rdata=0",
                         k, ta[k], o.ack, o.ce, o.lat, o.resp, o.rdata, !te[k], te[k]);
            end
        end
    endtask

    task automatic test_wait();
        obs_t o;
        logic        a_s [8];
        logic [1:0]  r_s [8];
        logic [31:0] d_s [8];
        xact(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0001_0004, 32'h1234_5678, o);
        checks++;
        if (o.lat != 3 || o.resp !== SCR1_MEM_RESP_RDY_OK) begin
            failures++; $display("FAIL wait_sw got lat=%0d resp=%0d exp 3 1", o.lat, o.resp);
        end
        @(posedge clk); #1;
        req[1] = 1'b1; cmd[1] = SCR1_MEM_CMD_RD; wid[1] = SCR1_MEM_WIDTH_WORD; addr[1] = 32'h0001_0004;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) begin @(posedge clk); #1; req[1] = 1'b0; end
            @(negedge clk);
            a_s[k] = ack[1]; r_s[k] = rsp[1]; d_s[k] = rdat[1];
        end
        checks++;
        if ({a_s[0], a_s[1], a_s[2], a_s[3], a_s[4]} !== 5'b10001) begin
            failures++; $display("FAIL wait_ack got=%b exp=10001", {a_s[0], a_s[1], a_s[2], a_s[3], a_s[4]});
        end
        checks++;
        if ({r_s[0], r_s[1], r_s[2], r_s[3], r_s[4]} !== {2'd0, 2'd0, 2'd0, 2'd1, 2'd0} || d_s[3] !== 32'h1234_5678) begin
            failures++; $display("FAIL wait_resp got=%b data=%h exp=0000000100 12345678", {r_s[0], r_s[1], r_s[2], r_s[3], r_s[4]}, d_s[3]);
        end
        checks++;
        if (r_s[5] !== 2'd0 || r_s[6] !== 2'd0 || r_s[7] !== 2'd1 || d_s[7] !== 32'h1234_5678) begin
            failures++; $display("FAIL wait_second got resp=%0d,%0d,%0d data=%h exp 0,0,1 12345678", r_s[5], r_s[6], r_s[7], d_s[7]);
        end
    endtask

    task automatic test_reset_mid();
        logic        a0, a1, ce1, a2;
        logic [1:0]  r_s [6];
        logic [31:0] d5;
        @(posedge clk); #1;
        req[1] = 1'b1; cmd[1] = SCR1_MEM_CMD_RD; wid[1] = SCR1_MEM_WIDTH_WORD; addr[1] = 32'h0001_0004;
        @(negedge clk); a0 = ack[1]; r_s[0] = rsp[1];
        @(posedge clk); #1; rst[1] = 1'b1;
        @(negedge clk); a1 = ack[1]; ce1 = ce[1]; r_s[1] = rsp[1];
        @(posedge clk); #1; rst[1] = 1'b0;
        @(negedge clk); a2 = ack[1]; r_s[2] = rsp[1];
        @(posedge clk); #1; req[1] = 1'b0;
        for (int k = 3; k < 6; k++) begin @(negedge clk); r_s[k] = rsp[1]; end
        d5 = rdat[1];
        checks++;
        if ({a0, a1, ce1, a2} !== 4'b1001) begin
            failures++; $display("FAIL rstmid_ack got ack0/ack1/ce1/ack2=%b exp=1001", {a0, a1, ce1, a2});
        end
        checks++;
        if ({r_s[0], r_s[1], r_s[2], r_s[3], r_s[4]} !== 10'd0) begin
            failures++; $display("FAIL rstmid_dropped got=%b exp=0000000000", {r_s[0], r_s[1], r_s[2], r_s[3], r_s[4]});
        end
        checks++;
        if (r_s[5] !== 2'd1 || d5 !== 32'h1234_5678) begin
            failures++; $display("FAIL rstmid_next got resp=%0d data=%h exp 1 12345678", r_s[5], d5);
        end
    endtask

    task automatic test_back_to_back();
        logic        a_s [4];
        logic [1:0]  r_s [4];
        logic [31:0] d_s [4];
        @(posedge clk); #1;
        req[0] = 1'b1; cmd[0] = SCR1_MEM_CMD_RD; wid[0] = SCR1_MEM_WIDTH_WORD; addr[0] = 32'h0001_0004;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin @(posedge clk); #1; req[0] = 1'b0; end
            @(negedge clk);
            a_s[k] = ack[0]; r_s[k] = rsp[0]; d_s[k] = rdat[0];
        end
        checks++;
        if ({a_s[0], a_s[1], a_s[2], a_s[3]} !== 4'b1010) begin
            failures++; $display("FAIL b2b_ack got=%b exp=1010", {a_s[0], a_s[1], a_s[2], a_s[3]});
        end
        checks++;
        if (r_s[1] !== 2'd1 || d_s[1] !== 32'hDEA5_BEEF || r_s[2] !== 2'd0 || r_s[3] !== 2'd1 || d_s[3] !== 32'hDEA5_BEEF) begin
            failures++; $display("FAIL b2b_resp got %0d/%h %0d %0d/%h exp 1/dea5beef 0 1/dea5beef", r_s[1], d_s[1], r_s[2], r_s[3], d_s[3]);
        end
    endtask

    task automatic test_random();
        obs_t o;
        type_scr1_mem_cmd_e   c;
        type_scr1_mem_width_e w;
        logic [31:0] a, wd, exp_rd, exp_sw;
        logic [3:0]  exp_be;
        bit          err;
        int          r, n, off;
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 150; t++) begin
                c = type_scr1_mem_cmd_e'(1'($urandom_range(0, 1)));
                r = int'($urandom_range(0, 99));
                w = (r < 5) ? SCR1_MEM_WIDTH_ERROR : type_scr1_mem_width_e'(2'($urandom_range(0, 2)));
                r = int'($urandom_range(0, 99));
                if (r < 85)      a = BASE + 32'($urandom_range(0, 63));
                else if (r < 92) a = BASE + SIZE - 4 + 32'($urandom_range(0, 3));
                else             a = $urandom;
                wd  = $urandom;
                err = model_err(w, a);
                n   = nbytes(w);
                off = int'(a % 4);
                exp_rd = (!err && c == SCR1_MEM_CMD_RD) ? model_load(d, w, a) : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    exp_be[i] = (c == SCR1_MEM_CMD_WR) && !err && (i >= off) && (i < off + n);
                    exp_sw[8*i +: 8] = wd[8*(i % n) +: 8];
                end
                xact(d, c, w, a, wd, o);
                checks++;
                if (o.timeout || o.ack !== 1'b1 || o.resp_t !== SCR1_MEM_RESP_NOTRDY) begin
                    failures++; $display("FAIL rnd_accept d=%0d t=%0d got ack=%b resp_at_accept=%0d exp 1 0", d, t, o.ack, o.resp_t);
                end
                checks++;
                if (o.ce !== !err || o.we !== (!err && c == SCR1_MEM_CMD_WR) || o.be !== exp_be) begin
                    failures++; $display("FAIL rnd_strobe d=%0d t=%0d addr=%h got ce=%b we=%b be=%b exp ce=%b be=%b", d, t, a, o.ce, o.we, o.be, !err, exp_be);
                end
                if (!err && c == SCR1_MEM_CMD_WR) begin
                    checks++;
                    if (o.swdata !== exp_sw || o.saddr !== a[11:2]) begin
                        failures++; $display("FAIL rnd_wdata d=%0d t=%0d got %h@%0d exp %h@%0d", d, t, o.swdata, o.saddr, exp_sw, a[11:2]);
                    end
                end
                checks++;
                if (o.lat != 1 + wait_of(d) || o.resp !== (err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK) || o.rdata !== exp_rd) begin
                    failures++; $display("FAIL rnd_resp d=%0d t=%0d addr=%h got lat=%0d resp=%0d rdata=%h exp lat=%0d err=%b rdata=%h",
                                         d, t, a, o.lat, o.resp, o.rdata, 1 + wait_of(d), err, exp_rd);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; cmd[d] = SCR1_MEM_CMD_RD; wid[d] = SCR1_MEM_WIDTH_WORD;
            addr[d] = '0; wdat[d] = '0;
            for (int i = 0; i < SIZE; i++) ref_mem[d][i] = 8'h00;
        end
        test_reset();
        test_store_load();
        test_error();
        test_back_to_back();
        test_wait();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
